// File: rtl/otter_cu_decode_pipe_if.sv
// Fetch-to-execute handshake bundle for the registered OTTER decode stage.
// The master drives instructions and downstream ready; the slave is the decoder.
interface otter_cu_decode_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_ir;
  logic [XLEN-1:0] in_pc;
  logic            br_eq;
  logic            br_lt;
  logic            br_ltu;
  logic            flush;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic            out_alu_srca;
  logic [1:0]      out_alu_srcb;
  logic [3:0]      out_alu_fun;
  logic [1:0]      out_rf_wr_sel;
  logic [2:0]      out_pc_source;
  logic            out_mem_we;
  logic            out_mem_re;
  logic [2:0]      out_msize;
  logic            out_rf_we;
  logic            out_illegal;

  modport master (
    output in_valid, in_ir, in_pc, br_eq, br_lt, br_ltu, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_alu_srca, out_alu_srcb,
           out_alu_fun, out_rf_wr_sel, out_pc_source, out_mem_we, out_mem_re,
           out_msize, out_rf_we, out_illegal
  );

  modport slave (
    input  in_valid, in_ir, in_pc, br_eq, br_lt, br_ltu, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_alu_srca, out_alu_srcb,
           out_alu_fun, out_rf_wr_sel, out_pc_source, out_mem_we, out_mem_re,
           out_msize, out_rf_we, out_illegal
  );
endinterface

// File: rtl/otter_cu_decode_pipe.sv
// Registered OTTER control decoder with valid/ready, branch resolve and load-use bubble.
// Define OTTER_DEC_PERF_EN to build the saturating hazard-bubble counter.
module otter_cu_decode_pipe #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  otter_cu_decode_pipe_if.slave bus,
  output logic [PERF_W-1:0] perf_bubbles_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7b5;
  logic [4:0] rd, rs1, rs2;
  logic       unused_ir;

  assign opcode    = bus.in_ir[6:0];
  assign rd        = bus.in_ir[11:7];
  assign f3        = bus.in_ir[14:12];
  assign rs1       = bus.in_ir[19:15];
  assign rs2       = bus.in_ir[24:20];
  assign f7b5      = bus.in_ir[30];
  assign unused_ir = ^{bus.in_ir[31], bus.in_ir[29:25]};

  logic       illegal_d, srca_d, mem_we_d, mem_re_d, rf_we_d;
  logic [1:0] srcb_d, wr_sel_d;
  logic [3:0] alu_fun_d;
  logic [2:0] pc_src_d, msize_d;
  logic       br_taken, uses_rs1, uses_rs2;

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'b000:  br_taken = bus.br_eq;
      3'b001:  br_taken = !bus.br_eq;
      3'b100:  br_taken = bus.br_lt;
      3'b101:  br_taken = !bus.br_lt;
      3'b110:  br_taken = bus.br_ltu;
      3'b111:  br_taken = !bus.br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    illegal_d = 1'b0;
    srca_d    = 1'b0;
    srcb_d    = 2'd0;
    alu_fun_d = 4'b0000;
    wr_sel_d  = 2'd3;
    pc_src_d  = 3'd0;
    mem_we_d  = 1'b0;
    mem_re_d  = 1'b0;
    msize_d   = 3'd0;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        srca_d    = 1'b1;
        alu_fun_d = 4'b1001;
        uses_rs1  = 1'b0;
      end
      OPC_AUIPC: begin
        srca_d   = 1'b1;
        srcb_d   = 2'd3;
        uses_rs1 = 1'b0;
      end
      OPC_JAL: begin
        wr_sel_d = 2'd0;
        pc_src_d = 3'd3;
        uses_rs1 = 1'b0;
      end
      OPC_JALR: begin
        srcb_d   = 2'd1;
        wr_sel_d = 2'd0;
        pc_src_d = 3'd1;
      end
      OPC_BRANCH: begin
        pc_src_d = br_taken ? 3'd2 : 3'd0;
        uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        srcb_d   = 2'd1;
        wr_sel_d = 2'd2;
        mem_re_d = 1'b1;
        msize_d  = f3;
      end
      OPC_STORE: begin
        srcb_d   = 2'd2;
        mem_we_d = 1'b1;
        msize_d  = f3;
        uses_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        srcb_d    = 2'd1;
        alu_fun_d = (f3 == 3'b101) ? {f7b5, f3} : {1'b0, f3};
      end
      OPC_OP: begin
        alu_fun_d = {f7b5, f3};
        uses_rs2  = 1'b1;
      end
      OPC_SYSTEM: begin
        alu_fun_d = 4'b1001;
        wr_sel_d  = 2'd1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  assign rf_we_d = !illegal_d && (rd != 5'd0)
                && (opcode != OPC_BRANCH) && (opcode != OPC_STORE)
                && !((opcode == OPC_SYSTEM) && (f3 == 3'b000));

  logic            out_valid_q, load_pend_q;
  logic [4:0]      load_rd_q, out_rd_q;
  logic [XLEN-1:0] out_pc_q;
  logic            srca_q, mem_we_q, mem_re_q, rf_we_q, illegal_q;
  logic [1:0]      srcb_q, wr_sel_q;
  logic [3:0]      alu_fun_q;
  logic [2:0]      pc_src_q, msize_q;
  logic            adv, hazard, take;

  assign adv    = !out_valid_q || bus.out_ready;
  assign hazard = load_pend_q && ((uses_rs1 && (rs1 == load_rd_q))
                               || (uses_rs2 && (rs2 == load_rd_q)));
  assign bus.in_ready = adv && !hazard && !bus.flush;
  assign take   = bus.in_valid && !hazard;

  // FLUSH outranks adv; a stalled or empty advance drops the slot and the pending load
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      load_pend_q <= 1'b0;
      load_rd_q   <= 5'd0;
      out_pc_q    <= '0;
      out_rd_q    <= 5'd0;
      srca_q      <= 1'b0;
      srcb_q      <= 2'd0;
      alu_fun_q   <= 4'd0;
      wr_sel_q    <= 2'd0;
      pc_src_q    <= 3'd0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      msize_q     <= 3'd0;
      rf_we_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      load_pend_q <= 1'b0;
    end else if (adv) begin
      if (take) begin
        out_valid_q <= 1'b1;
        load_pend_q <= (opcode == OPC_LOAD) && (rd != 5'd0);
        load_rd_q   <= rd;
        out_pc_q    <= bus.in_pc;
        out_rd_q    <= rd;
        srca_q      <= srca_d;
        srcb_q      <= srcb_d;
        alu_fun_q   <= alu_fun_d;
        wr_sel_q    <= wr_sel_d;
        pc_src_q    <= pc_src_d;
        mem_we_q    <= mem_we_d;
        mem_re_q    <= mem_re_d;
        msize_q     <= msize_d;
        rf_we_q     <= rf_we_d;
        illegal_q   <= illegal_d;
      end else begin
        out_valid_q <= 1'b0;
        load_pend_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_pc        = out_pc_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_alu_srca  = srca_q;
  assign bus.out_alu_srcb  = srcb_q;
  assign bus.out_alu_fun   = alu_fun_q;
  assign bus.out_rf_wr_sel = wr_sel_q;
  assign bus.out_pc_source = pc_src_q;
  assign bus.out_mem_we    = mem_we_q;
  assign bus.out_mem_re    = mem_re_q;
  assign bus.out_msize     = msize_q;
  assign bus.out_rf_we     = rf_we_q;
  assign bus.out_illegal   = illegal_q;

`ifdef OTTER_DEC_PERF_EN
  logic [PERF_W-1:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (adv && bus.in_valid && hazard && !bus.flush && (perf_q != '1)) begin
      perf_q <= perf_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end

  assign perf_bubbles_o = perf_q;
`else
  assign perf_bubbles_o = '0;
`endif

endmodule

// File: tb/tb_otter_cu_decode_pipe.sv
// Randomized bench for otter_cu_decode_pipe against a cycle-level reference model.
module tb_otter_cu_decode_pipe;
  localparam int XLEN   = 32;
  localparam int PERF_W = 16;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  logic              clk_sys = 1'b0;
  logic              rst_n;
  logic [PERF_W-1:0] perf_bubbles;

  always #5 clk_sys = ~clk_sys;

  otter_cu_decode_pipe_if #(.XLEN(XLEN)) bus ();

  otter_cu_decode_pipe #(.XLEN(XLEN), .PERF_W(PERF_W)) dut (
    .clk_i          (clk_sys),
    .rst_ni         (rst_n),
    .bus            (bus),
    .perf_bubbles_o (perf_bubbles)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference state: the slot execute should see, and the load whose result is not yet usable
  logic        m_valid;
  logic [55:0] m_slot;
  bit          m_pend;
  int          m_pend_rd;
  int          m_perf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2,
                                      input logic [4:0] r1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {f7, r2, r1, f3, rd, op};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM};
  endfunction

  // Field layout: pc, rd, srca, srcb, fun, wr_sel, pc_src, mem_we, mem_re, msize, rf_we, illegal
  function automatic logic [55:0] ref_decode(input logic [31:0] ir, input logic [31:0] pc,
                                             input bit eq, input bit lt, input bit ltu);
    logic [6:0] op = ir[6:0];
    int f3 = int'(ir[14:12]);
    int rd = int'(ir[11:7]);
    bit ill = !is_legal(op);
    bit taken;
    int srca, srcb, fun, wsel, pcs, we, re, msz, rfwe;
    case (f3)
      0: taken = eq;
      1: taken = !eq;
      4: taken = lt;
      5: taken = !lt;
      6: taken = ltu;
      7: taken = !ltu;
      default: taken = 0;
    endcase
    srca = (op == LUI || op == AUIPC) ? 1 : 0;
    if (op == STORE) srcb = 2;
    else if (op == LOAD || op == JALR || op == OP_IMM) srcb = 1;
    else if (op == AUIPC) srcb = 3;
    else srcb = 0;
    if (op == OP) fun = int'(ir[30]) * 8 + f3;
    else if (op == OP_IMM) fun = (f3 == 5) ? int'(ir[30]) * 8 + f3 : f3;
    else if (op == LUI || op == SYSTEM) fun = 9;
    else fun = 0;
    if (op == JAL || op == JALR) wsel = 0;
    else if (op == SYSTEM) wsel = 1;
    else if (op == LOAD) wsel = 2;
    else wsel = 3;
    if (op == JALR) pcs = 1;
    else if (op == BRANCH && taken) pcs = 2;
    else if (op == JAL) pcs = 3;
    else pcs = 0;
    we   = (op == STORE) ? 1 : 0;
    re   = (op == LOAD) ? 1 : 0;
    msz  = (op == LOAD || op == STORE) ? f3 : 0;
    rfwe = (ill || op == BRANCH || op == STORE || rd == 0 || (op == SYSTEM && f3 == 0)) ? 0 : 1;
    return {pc, 5'(rd), 1'(srca), 2'(srcb), 4'(fun), 2'(wsel), 3'(pcs),
            1'(we), 1'(re), 3'(msz), 1'(rfwe), ill};
  endfunction

  function automatic logic [55:0] dut_slot();
    return {bus.out_pc, bus.out_rd, bus.out_alu_srca, bus.out_alu_srcb, bus.out_alu_fun,
            bus.out_rf_wr_sel, bus.out_pc_source, bus.out_mem_we, bus.out_mem_re,
            bus.out_msize, bus.out_rf_we, bus.out_illegal};
  endfunction

  task automatic model_reset();
    m_valid   = 1'b0;
    m_slot    = '0;
    m_pend    = 0;
    m_pend_rd = 0;
    m_perf    = 0;
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".valid"}, 64'(bus.out_valid), 64'(m_valid));
    chk({where, ".slot"},  64'(dut_slot()),    64'(m_slot));
`ifdef OTTER_DEC_PERF_EN
    chk({where, ".perf"},  64'(perf_bubbles),  64'(m_perf));
`else
    chk({where, ".perf"},  64'(perf_bubbles),  64'd0);
`endif
  endtask

  // Called just after a falling edge; leaves the bench just after the next falling edge.
  task automatic step(input bit v, input logic [31:0] ir, input logic [31:0] pc,
                      input bit eq, input bit lt, input bit ltu,
                      input bit fl, input bit ordy);
    logic [6:0] op;
    int  r1, r2;
    bit  adv, haz, exp_ready;
    check_outputs("out");
    bus.in_valid  = v;
    bus.in_ir     = ir;
    bus.in_pc     = pc;
    bus.br_eq     = eq;
    bus.br_lt     = lt;
    bus.br_ltu    = ltu;
    bus.flush     = fl;
    bus.out_ready = ordy;
    #1;
    op  = ir[6:0];
    r1  = int'(ir[19:15]);
    r2  = int'(ir[24:20]);
    adv = !m_valid || ordy;
    haz = m_pend && ((!(op inside {LUI, AUIPC, JAL}) && r1 == m_pend_rd)
                  || ((op inside {OP, STORE, BRANCH}) && r2 == m_pend_rd));
    exp_ready = adv && !haz && !fl;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    @(posedge clk_sys);
    if (fl) begin
      m_valid = 1'b0;
      m_pend  = 0;
    end else if (adv) begin
      if (v && haz && m_perf < (1 << PERF_W) - 1) m_perf++;
      if (v && !haz) begin
        m_slot    = ref_decode(ir, pc, eq, lt, ltu);
        m_valid   = 1'b1;
        m_pend    = (op == LOAD) && (ir[11:7] != 5'd0);
        m_pend_rd = int'(ir[11:7]);
      end else begin
        m_valid = 1'b0;
        m_pend  = 0;
      end
    end
    @(negedge clk_sys);
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 10))
      0: r[6:0] = LUI;
      1: r[6:0] = AUIPC;
      2: r[6:0] = JAL;
      3: r[6:0] = JALR;
      4: r[6:0] = BRANCH;
      5, 6: r[6:0] = LOAD;
      7: r[6:0] = STORE;
      8: r[6:0] = OP_IMM;
      9: r[6:0] = OP;
      default: r[6:0] = ($urandom_range(0, 1) == 0) ? SYSTEM : 7'($urandom);
    endcase
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  logic [31:0] sw_ir;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_ir     = '0;
    bus.in_pc     = '0;
    bus.br_eq     = 1'b0;
    bus.br_lt     = 1'b0;
    bus.br_ltu    = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    #2;
    check_outputs("reset");
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);

    // ADD x3,x1,x2 then SUB x4,x1,x2, back to back
    step(1, enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OP), 32'h100, 0, 0, 0, 0, 1);
    step(1, enc(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, OP), 32'h104, 0, 0, 0, 0, 1);
    chk("sub.fun", 64'(bus.out_alu_fun), 64'd8);
    // LW x5,0(x1) then dependent ADD x6,x5,x2: one bubble
    step(1, enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, LOAD), 32'h108, 0, 0, 0, 0, 1);
    step(1, enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, OP), 32'h10c, 0, 0, 0, 0, 1);
    chk("bubble.valid", 64'(bus.out_valid), 64'd0);
    step(1, enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, OP), 32'h10c, 0, 0, 0, 0, 1);
    // BNE not-equal taken, BGEU with LTU set not taken
    step(1, enc(7'h00, 5'd2, 5'd1, 3'd1, 5'd0, BRANCH), 32'h110, 0, 0, 0, 0, 1);
    step(1, enc(7'h00, 5'd2, 5'd1, 3'd7, 5'd0, BRANCH), 32'h114, 0, 0, 1, 0, 1);
    // SW held with downstream stalled
    sw_ir = enc(7'h00, 5'd2, 5'd1, 3'd2, 5'd8, STORE);
    step(1, sw_ir, 32'h118, 0, 0, 0, 0, 0);
    step(1, sw_ir, 32'h11c, 0, 0, 0, 0, 0);
    step(1, sw_ir, 32'h11c, 0, 0, 0, 0, 0);
    step(1, sw_ir, 32'h11c, 0, 0, 0, 0, 1);
    // LW x5 then flush while the dependent ADD waits
    step(1, enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, LOAD), 32'h120, 0, 0, 0, 0, 1);
    step(1, enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, OP), 32'h124, 0, 0, 0, 1, 1);
    step(1, enc(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, OP), 32'h124, 0, 0, 0, 0, 1);
    // illegal opcode, then reset while stalled
    step(1, enc(7'h00, 5'd2, 5'd1, 3'd2, 5'd7, 7'h7f), 32'h128, 0, 0, 0, 0, 1);
    chk("illegal.flag", 64'(bus.out_illegal), 64'd1);
    chk("illegal.rf_we", 64'(bus.out_rf_we), 64'd0);
    chk("illegal.mem_we", 64'(bus.out_mem_we), 64'd0);
    step(1, sw_ir, 32'h12c, 0, 0, 0, 0, 0);
    step(1, sw_ir, 32'h130, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midreset");
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk_sys);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rand_ir(), $urandom,
           1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end
    check_outputs("final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/otter_cu_decode_pipe.md
Name:
otter_cu_decode_pipe

Overview:
Registered, handshaked successor to the OTTER combinational control decoder. It sits between fetch and execute: it accepts one instruction per cycle over valid/ready, decodes ALU, writeback and memory controls, resolves branch direction, and inserts a one-cycle bubble on a load-use hazard.

Parameters:
XLEN, 32, width of IN_PC/OUT_PC
PERF_W, 16, width of the hazard-bubble counter (used only with the optional feature)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous reset, active-low
IN_VALID  in  1  instruction offered
IN_READY  out  1  instruction accepted this cycle when IN_VALID&&IN_READY
IN_IR  in  32  instruction word
IN_PC  in  XLEN  PC of IN_IR
BR_EQ  in  1  rs1==rs2 for IN_IR
BR_LT  in  1  signed rs1<rs2 for IN_IR
BR_LTU  in  1  unsigned rs1<rs2 for IN_IR
FLUSH  in  1  kill output slot and pending hazard
OUT_VALID  out  1  decoded slot valid
OUT_READY  in  1  downstream takes slot
OUT_PC  out  XLEN  registered IN_PC
OUT_RD  out  5  IR[11:7]
OUT_ALU_SRCA  out  1  1 for LUI/AUIPC, else 0
OUT_ALU_SRCB  out  2  STORE 2; LOAD/JALR/OP_IMM 1; AUIPC 3; else 0
OUT_ALU_FUN  out  4  see Behaviour
OUT_RF_WR_SEL  out  2  JAL/JALR 0; SYSTEM 1; LOAD 2; else 3
OUT_PC_SOURCE  out  3  0 PC+4, 1 JALR, 2 taken branch, 3 JAL
OUT_MEM_WE  out  1  STORE
OUT_MEM_RE  out  1  LOAD
OUT_MSIZE  out  3  IR[14:12] for LOAD/STORE, else 0
OUT_RF_WE  out  1  register-file write enable
OUT_ILLEGAL  out  1  opcode outside {LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP_IMM,OP,SYSTEM}
PERF_BUBBLES  out  PERF_W  saturating hazard-bubble count

Behaviour:
- Reset (RST_N=0, asynchronous): every output register is 0, including OUT_VALID and the hidden LOAD_PEND and LOAD_RD registers. Reset mid-transfer discards the slot.
- ALU_FUN:
  - OP: {f7[5],f3}.
  - OP_IMM: {f7[5],f3} when f3==101, else {0,f3}.
  - LUI and SYSTEM: 1001.
  - All other opcodes: 0000.
- Branch taken by f3: 000 EQ, 001 !EQ, 100 LT, 101 !LT, 110 LTU, 111 !LTU; 010 and 011 are not taken. BR_* are sampled with IN_IR.
- RF_WE=1 unless any of these holds: the opcode is BRANCH or STORE; rd==0; SYSTEM with f3==000; illegal opcode. Illegal opcodes also force MEM_WE=MEM_RE=0 and PC_SOURCE=0, and OUT_VALID stays 1.
- adv = !OUT_VALID || OUT_READY.
- Hazard: LOAD_PEND && (rs1==LOAD_RD when the opcode uses rs1 (all except LUI/AUIPC/JAL), or rs2==LOAD_RD when it uses rs2 (OP/STORE/BRANCH)).
- IN_READY = adv && !hazard && !FLUSH. IN_READY is combinational from OUT_READY, FLUSH and IN_IR.
- Priority each cycle: FLUSH, then adv.
  - FLUSH: OUT_VALID<=0 and LOAD_PEND<=0 regardless of adv.
  - adv with a transfer: load all decoded fields and set OUT_VALID<=1. LOAD_PEND<=(LOAD && rd!=0), LOAD_RD<=rd.
  - adv without a transfer (no IN_VALID, or a hazard): OUT_VALID<=0 and LOAD_PEND<=0. A hazard therefore costs exactly one bubble.
  - !adv: hold all outputs stable while OUT_VALID && !OUT_READY.
- Throughput is 1 instruction/cycle with no hazard. Latency is 1 cycle from input accept to OUT_VALID.

Optional Feature:
OTTER_DEC_PERF_EN:
- Defined: PERF_BUBBLES increments on each cycle with adv && IN_VALID && hazard && !FLUSH, saturates at all-ones, and resets to 0.
- Undefined: PERF_BUBBLES is tied to 0 and no counter logic exists.

Test Plan:
- Stream ADD x3,x1,x2 then SUB x4,x1,x2 with OUT_READY=1 -> OUT_ALU_FUN 0000 then 1000, back-to-back OUT_VALID, RF_WE=1, RF_WR_SEL=3.
- LW x5,0(x1) then ADD x6,x5,x2 -> IN_READY=0 for one cycle, one OUT_VALID=0 bubble, ADD emerges next; PERF_BUBBLES=1 with the macro, 0 without.
- BNE with BR_EQ=0, then BGEU with BR_LTU=1 -> OUT_PC_SOURCE 2 then 0; RF_WE=0 for both.
- Hold OUT_READY=0 for 3 cycles with SW valid -> outputs stable (MEM_WE=1, SRCB=2, MSIZE=010), IN_READY=0.
- LW x5 accepted, then FLUSH with dependent ADD x6,x5,x2 waiting -> OUT_VALID=0 next cycle, LOAD_PEND cleared, ADD accepted the following cycle with no bubble.
- Opcode 1111111 -> OUT_ILLEGAL=1, RF_WE=0, MEM_WE=0; assert RST_N mid-stall -> all outputs 0 immediately.
